// File: rtl/sd_clk_rate_controller_if.sv
// Handshake bundle between the SD clock-rate controller, the init FSM, the
// divide-count generator and the SD clock divider.
interface sd_clk_rate_controller_if;
  logic        cfg_req;
  logic        cfg_mode;
  logic [7:0]  csd_tran_speed;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [15:0] cur_count;
  logic        sd_clk_en;
  logic [7:0]  gen_tran_speed;
  logic        gen_start;
  logic        gen_ok;
  logic        gen_err;
  logic [15:0] gen_count;
  logic        div_load;

  // Controller side
  modport slave (
    input  cfg_req, cfg_mode, csd_tran_speed, gen_ok, gen_err, gen_count,
    output cfg_busy, cfg_done, cfg_err, cur_count, sd_clk_en,
           gen_tran_speed, gen_start, div_load
  );

  // Surrounding logic: init FSM, count generator and divider
  modport master (
    output cfg_req, cfg_mode, csd_tran_speed, gen_ok, gen_err, gen_count,
    input  cfg_busy, cfg_done, cfg_err, cur_count, sd_clk_en,
           gen_tran_speed, gen_start, div_load
  );
endinterface

// File: rtl/sd_clk_rate_controller.sv
// Sequences an SD clock-rate change: gate clock, run the count generator,
// reload the divider, ungate. Any failure applies a safe identification count.
module sd_clk_rate_controller #(
  parameter logic [7:0]  ID_TRAN_SPEED  = 8'h48,
  parameter logic [15:0] FALLBACK_COUNT = 16'd125,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          GATE_CYCLES    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  sd_clk_rate_controller_if.slave     bus
);

  typedef enum logic [3:0] {
    IDLE, GATE_OFF, CHECK, SETUP, START, WAIT, FAIL, APPLY, GATE_ON, DONE
  } state_t;

  localparam logic [6:0] TIMER_LAST = 7'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GATE_LAST  = 8'(GATE_CYCLES - 1);

  state_t      state;
  logic [7:0]  sel_code;
  logic [6:0]  timer;
  logic [7:0]  gate_cnt;
  logic        cfg_busy_q;
  logic        cfg_done_q;
  logic        cfg_err_q;
  logic [15:0] cur_count_q;
  logic        sd_clk_en_q;
  logic [7:0]  gen_tran_speed_q;
  logic        gen_start_q;
  logic        div_load_q;

  // A zero rate-multiplier field or the reserved top bit cannot be divided.
  function automatic logic code_legal(input logic [7:0] code);
    return (code[6:3] != 4'd0) && !code[7];
  endfunction

  function automatic logic [6:0] timer_inc(input logic [6:0] t);
    return (t == 7'h7f) ? t : t + 7'd1;
  endfunction

  // Requested code is captured once at acceptance; later CSD changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cfg_req)
      sel_code <= bus.cfg_mode ? bus.csd_tran_speed : ID_TRAN_SPEED;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      timer            <= 7'd0;
      gate_cnt         <= 8'd0;
      cfg_busy_q       <= 1'b0;
      cfg_done_q       <= 1'b0;
      cfg_err_q        <= 1'b0;
      cur_count_q      <= FALLBACK_COUNT;
      sd_clk_en_q      <= 1'b0;
      gen_tran_speed_q <= ID_TRAN_SPEED;
      gen_start_q      <= 1'b0;
      div_load_q       <= 1'b0;
    end else begin
      gen_start_q <= 1'b0;
      div_load_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cfg_req) begin
            state       <= GATE_OFF;
            cfg_busy_q  <= 1'b1;
            cfg_err_q   <= 1'b0;
            sd_clk_en_q <= 1'b0;
            gate_cnt    <= 8'd0;
          end
        end
        GATE_OFF: begin
          if (gate_cnt == GATE_LAST) state <= CHECK;
          else gate_cnt <= gate_cnt + 8'd1;
        end
        CHECK: begin
          if (code_legal(sel_code)) begin
            gen_tran_speed_q <= sel_code;
            state            <= SETUP;
          end else begin
            state <= FAIL;
          end
        end
        SETUP: state <= START;
        START: begin
          gen_start_q <= 1'b1;
          timer       <= 7'd0;
          state       <= WAIT;
        end
        // gen_err has priority over a coincident gen_ok.
        WAIT: begin
          timer <= timer_inc(timer);
          if (bus.gen_err) begin
            state <= FAIL;
          end else if (bus.gen_ok) begin
            if (bus.gen_count != 16'd0) begin
              cur_count_q <= bus.gen_count;
              state       <= APPLY;
            end else begin
              state <= FAIL;
            end
          end else if (timer == TIMER_LAST) begin
            state <= FAIL;
          end
        end
        FAIL: begin
          cur_count_q <= FALLBACK_COUNT;
          cfg_err_q   <= 1'b1;
          state       <= APPLY;
        end
        APPLY: begin
          div_load_q <= 1'b1;
          gate_cnt   <= 8'd0;
          state      <= GATE_ON;
        end
        // Clock stays gated while the divider settles on the new count.
        GATE_ON: begin
          if (gate_cnt == GATE_LAST) begin
            sd_clk_en_q <= 1'b1;
            state       <= DONE;
          end else begin
            gate_cnt <= gate_cnt + 8'd1;
          end
        end
        DONE: begin
          cfg_done_q <= 1'b1;
          cfg_busy_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_busy       = cfg_busy_q;
  assign bus.cfg_done       = cfg_done_q;
  assign bus.cfg_err        = cfg_err_q;
  assign bus.cur_count      = cur_count_q;
  assign bus.sd_clk_en      = sd_clk_en_q;
  assign bus.gen_tran_speed = gen_tran_speed_q;
  assign bus.gen_start      = gen_start_q;
  assign bus.div_load       = div_load_q;

endmodule

// File: tb/tb_sd_clk_rate_controller.sv
// Directed bench for sd_clk_rate_controller with GATE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_sd_clk_rate_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  int   gs_cnt = 0, dl_cnt = 0, done_cnt = 0;
  int   dl_cyc = 0, done_cyc = 0, en_rise_cyc = 0;
  logic en_prev = 1'b0;
  logic [7:0] gts_seen = 8'h00;

  sd_clk_rate_controller_if bus ();

  sd_clk_rate_controller dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.gen_start) gs_cnt <= gs_cnt + 1;
    if (bus.div_load) begin
      dl_cnt <= dl_cnt + 1;
      dl_cyc <= cyc;
    end
    if (bus.cfg_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.sd_clk_en && !en_prev) en_rise_cyc <= cyc;
    en_prev <= bus.sd_clk_en;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic mode, input logic [7:0] spd, output int k);
    bus.cfg_mode       = mode;
    bus.csd_tran_speed = spd;
    bus.cfg_req        = 1'b1;
    k = cyc + 1;
    tick();
    bus.cfg_req = 1'b0;
  endtask

  task automatic wait_gs();
    for (int i = 0; i < 40; i++) begin
      if (bus.gen_start) begin
        gts_seen = bus.gen_tran_speed;
        return;
      end
      tick();
    end
    chk("gen_start_wait", 32'd0, 32'd1);
  endtask

  task automatic respond(input int n, input logic ok, input logic err, input logic [15:0] cnt);
    wait_gs();
    repeat (n) tick();
    bus.gen_ok    = ok;
    bus.gen_err   = err;
    bus.gen_count = cnt;
    tick();
    bus.gen_ok  = 1'b0;
    bus.gen_err = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int s;
    s = done_cnt;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cnt != s) return;
    end
    chk("done_wait", 32'd0, 32'd1);
  endtask

  initial begin
    int k, gs0, dl0, d0;
    bus.cfg_req = 1'b0;
    bus.cfg_mode = 1'b0;
    bus.csd_tran_speed = 8'h00;
    bus.gen_ok = 1'b0;
    bus.gen_err = 1'b0;
    bus.gen_count = 16'd0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 32'(bus.cfg_busy), 32'd0);
    chk("rst_done", 32'(bus.cfg_done), 32'd0);
    chk("rst_err", 32'(bus.cfg_err), 32'd0);
    chk("rst_count", 32'(bus.cur_count), 32'd125);
    chk("rst_en", 32'(bus.sd_clk_en), 32'd0);
    chk("rst_gts", 32'(bus.gen_tran_speed), 32'h48);
    chk("rst_start", 32'(bus.gen_start), 32'd0);
    chk("rst_load", 32'(bus.div_load), 32'd0);

    // Identification rate, response after 3 cycles
    gs0 = gs_cnt; dl0 = dl_cnt;
    send_req(1'b0, 8'h00, k);
    chk("t1_busy", 32'(bus.cfg_busy), 32'd1);
    respond(3, 1'b1, 1'b0, 16'd125);
    chk("t1_gts", 32'(gts_seen), 32'h48);
    wait_done(100);
    chk("t1_lat", 32'(done_cyc - k), 32'd17);
    chk("t1_gs", 32'(gs_cnt - gs0), 32'd1);
    chk("t1_dl", 32'(dl_cnt - dl0), 32'd1);
    chk("t1_count", 32'(bus.cur_count), 32'd125);
    chk("t1_en", 32'(bus.sd_clk_en), 32'd1);
    chk("t1_err", 32'(bus.cfg_err), 32'd0);
    chk("t1_busy_end", 32'(bus.cfg_busy), 32'd0);
    chk("t1_gate", 32'(en_rise_cyc - dl_cyc), 32'd4);
    tick();
    chk("t1_done_pulse", 32'(bus.cfg_done), 32'd0);

    // Transfer rate, immediate response; CSD byte changes after acceptance
    send_req(1'b1, 8'h32, k);
    bus.csd_tran_speed = 8'h03;
    chk("t2_en_off", 32'(bus.sd_clk_en), 32'd0);
    respond(0, 1'b1, 1'b0, 16'd2);
    chk("t2_gts", 32'(gts_seen), 32'h32);
    wait_done(100);
    chk("t2_lat", 32'(done_cyc - k), 32'd14);
    chk("t2_count", 32'(bus.cur_count), 32'd2);
    chk("t2_gate", 32'(en_rise_cyc - dl_cyc), 32'd4);
    chk("t2_err", 32'(bus.cfg_err), 32'd0);

    // Silent generator times out
    gs0 = gs_cnt;
    send_req(1'b1, 8'h32, k);
    wait_done(200);
    chk("t3_lat", 32'(done_cyc - k), 32'd78);
    chk("t3_count", 32'(bus.cur_count), 32'd125);
    chk("t3_err", 32'(bus.cfg_err), 32'd1);
    chk("t3_gs", 32'(gs_cnt - gs0), 32'd1);

    // Next request clears the error
    send_req(1'b0, 8'h00, k);
    chk("t4_err_clr", 32'(bus.cfg_err), 32'd0);
    respond(1, 1'b1, 1'b0, 16'd77);
    wait_done(100);
    chk("t4_lat", 32'(done_cyc - k), 32'd15);
    chk("t4_count", 32'(bus.cur_count), 32'd77);

    // Illegal code: zero multiplier field
    gs0 = gs_cnt; d0 = done_cnt;
    send_req(1'b1, 8'h03, k);
    wait_done(100);
    chk("t5_lat", 32'(done_cyc - k), 32'd12);
    chk("t5_gs", 32'(gs_cnt - gs0), 32'd0);
    chk("t5_done", 32'(done_cnt - d0), 32'd1);
    chk("t5_count", 32'(bus.cur_count), 32'd125);
    chk("t5_err", 32'(bus.cfg_err), 32'd1);
    chk("t5_gts", 32'(bus.gen_tran_speed), 32'h48);

    // gen_ok and gen_err together: error wins
    send_req(1'b1, 8'h32, k);
    chk("t6_err_clr", 32'(bus.cfg_err), 32'd0);
    respond(1, 1'b1, 1'b1, 16'd500);
    wait_done(100);
    chk("t6_lat", 32'(done_cyc - k), 32'd16);
    chk("t6_count", 32'(bus.cur_count), 32'd125);
    chk("t6_err", 32'(bus.cfg_err), 32'd1);

    // gen_ok with a zero count
    send_req(1'b0, 8'h00, k);
    respond(2, 1'b1, 1'b0, 16'd0);
    wait_done(100);
    chk("t7_lat", 32'(done_cyc - k), 32'd17);
    chk("t7_count", 32'(bus.cur_count), 32'd125);
    chk("t7_err", 32'(bus.cfg_err), 32'd1);

    // Request while busy is dropped
    gs0 = gs_cnt; d0 = done_cnt;
    send_req(1'b0, 8'h00, k);
    tick();
    bus.cfg_req = 1'b1;
    tick();
    bus.cfg_req = 1'b0;
    respond(2, 1'b1, 1'b0, 16'd900);
    wait_done(100);
    chk("t8_lat", 32'(done_cyc - k), 32'd16);
    repeat (30) tick();
    chk("t8_done", 32'(done_cnt - d0), 32'd1);
    chk("t8_gs", 32'(gs_cnt - gs0), 32'd1);
    chk("t8_count", 32'(bus.cur_count), 32'd900);
    chk("t8_err", 32'(bus.cfg_err), 32'd0);
    chk("t8_busy", 32'(bus.cfg_busy), 32'd0);

    // Reset during WAIT, then a late gen_ok
    send_req(1'b1, 8'h32, k);
    wait_gs();
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("t9_en", 32'(bus.sd_clk_en), 32'd0);
    chk("t9_count", 32'(bus.cur_count), 32'd125);
    chk("t9_busy", 32'(bus.cfg_busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    d0 = done_cnt; dl0 = dl_cnt;
    bus.gen_ok = 1'b1;
    bus.gen_count = 16'd42;
    tick();
    bus.gen_ok = 1'b0;
    repeat (5) tick();
    chk("t9_late_count", 32'(bus.cur_count), 32'd125);
    chk("t9_late_done", 32'(done_cnt - d0), 32'd0);
    chk("t9_late_dl", 32'(dl_cnt - dl0), 32'd0);
    chk("t9_late_en", 32'(bus.sd_clk_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_clk_rate_controller.md
Name: sd_clk_rate_controller

Overview:
Sequences the SD clock-rate change. On each request it gates the SD clock off and selects the identification-mode or CSD TRAN_SPEED code. It runs the divide-count generator and loads the resulting count into the SD clock divider, then re-enables the clock. Errors, timeouts and illegal codes fall back to a safe identification-rate count. It sits between the command/init FSM and the count generator / clock divider.

Parameters:
ID_TRAN_SPEED, 8'h48, TRAN_SPEED code for identification mode (40 x 10 kHz = 400 kHz).
FALLBACK_COUNT, 16'd125, count applied on any failure (50 MHz / 400 kHz).
TIMEOUT_CYCLES, 64, max cycles to wait for gen_ok/gen_err after gen_start.
GATE_CYCLES, 4, clk cycles the SD clock stays gated before and after a divider load.

Ports:
clk  in  1  system clock (50 MHz).
reset  in  1  asynchronous, active-low reset.
cfg_req  in  1  single-cycle request to (re)configure the SD clock rate.
cfg_mode  in  1  0 = identification rate (ID_TRAN_SPEED), 1 = transfer rate (csd_tran_speed).
csd_tran_speed  in  8  TRAN_SPEED byte from the CSD register.
cfg_busy  out  1  high from request acceptance until cfg_done.
cfg_done  out  1  one-cycle pulse when the new rate is live.
cfg_err  out  1  set when the fallback count was applied; held until the next accepted cfg_req.
cur_count  out  16  count currently loaded in the divider.
sd_clk_en  out  1  SD clock enable to the divider output gate.
gen_tran_speed  out  8  TRAN_SPEED code driven to the count generator.
gen_start  out  1  one-cycle start pulse to the count generator.
gen_ok  in  1  generator division complete.
gen_err  in  1  generator division error.
gen_count  in  16  generator result, valid with gen_ok.
div_load  out  1  one-cycle pulse; the divider reloads cur_count.

Behaviour:
- Reset (async assert, sync deassert by upstream): state IDLE, cfg_busy=0, cfg_done=0, cfg_err=0, cur_count=FALLBACK_COUNT, sd_clk_en=0, gen_tran_speed=ID_TRAN_SPEED, gen_start=0, div_load=0, timer=0. Reset mid-sequence aborts immediately. The SD clock stays off until a cfg_req completes.
- A cfg_req is accepted only in IDLE. A cfg_req while busy is ignored and not queued.
- States:
  - IDLE: on cfg_req -> GATE_OFF. Set cfg_busy=1, clear cfg_err, sd_clk_en=0, latch sel_code = cfg_mode ? csd_tran_speed : ID_TRAN_SPEED.
  - GATE_OFF: wait GATE_CYCLES, then go to CHECK.
  - CHECK: sel_code[6:3]==0 or sel_code[7]==1 is illegal -> FAIL, and the generator is not started. Otherwise drive gen_tran_speed=sel_code -> SETUP.
  - SETUP: one settle cycle for the generator rate decode -> START.
  - START: gen_start=1 for exactly one cycle, timer=0 -> WAIT.
  - WAIT: timer increments each cycle.
    - gen_err=1 -> FAIL. gen_err wins if gen_ok is in the same cycle.
    - gen_ok=1 and gen_count!=0 -> capture gen_count into cur_count -> APPLY.
    - gen_ok=1 and gen_count==0 -> FAIL.
    - timer reaches TIMEOUT_CYCLES-1 with no response -> FAIL.
  - FAIL: cur_count=FALLBACK_COUNT, cfg_err=1 -> APPLY.
  - APPLY: div_load=1 for one cycle -> GATE_ON.
  - GATE_ON: wait GATE_CYCLES, then sd_clk_en=1 -> DONE.
  - DONE: cfg_done=1 for one cycle, cfg_busy=0 -> IDLE.
- Latency for a legal code with generator response after N cycles (N counted from the cycle after gen_start): cfg_req to cfg_done = 2*GATE_CYCLES + N + 6 cycles.
- sd_clk_en falls the cycle after cfg_req is accepted. It rises only after div_load plus GATE_CYCLES, so the divider never toggles with the clock enabled during a reload.
- cur_count changes only in WAIT (on capture) or FAIL. It is stable at all other times.
- The timer is 7 bits wide and saturates. It cannot wrap within a sequence.
- gen_ok/gen_err pulses arriving outside WAIT are ignored.
- csd_tran_speed is sampled only at acceptance. Later changes do not affect an ongoing sequence.

Test Plan:
- Reset then cfg_req with cfg_mode=0, generator returns gen_ok with count 125 -> gen_tran_speed=8'h48, one gen_start, div_load once, cur_count=125, sd_clk_en=1, cfg_done pulse, cfg_err=0.
- cfg_mode=1, csd_tran_speed=8'h32, gen_count=2 -> cur_count=2. sd_clk_en is low from cycle after req through GATE_CYCLES after div_load.
- cfg_mode=1, csd_tran_speed=8'h03 (field 0) -> no gen_start, cur_count=125, cfg_err=1, cfg_done pulse.
- Generator silent for 64 cycles -> FAIL at timeout, cur_count=125, cfg_err=1. Also gen_ok and gen_err in the same cycle -> fallback applied.
- Second cfg_req pulsed while busy -> ignored: exactly one cfg_done and one gen_start. Next cfg_req after DONE clears cfg_err.
- reset asserted low during WAIT -> outputs immediately at reset values (sd_clk_en=0, cur_count=125, cfg_busy=0). A late gen_ok after release is ignored.
